// File: rtl/imem_access_sched.sv
`default_nettype none
// ============================================================================
// Module   : imem_access_sched
// Purpose  : Registered two-requester scheduler for a shared single-port
//            instruction memory. Port 1 (instruction fetch, read-only) has
//            priority; port 2 (loader/debugger, read/write) is guaranteed a
//            slot after at most MAXWAIT consecutive lost conflict cycles.
//            Drives the memory's active-low control pins and returns the
//            one-cycle-latency read data to whichever port issued the read.
//
// Ports    :
//   clk, rst          clock, synchronous active-high reset
//   p1_en_x/p1_addr   port 1 read request (active low) and address
//   p1_busy           port 1 request not accepted this cycle
//   p1_rvalid/rdata   port 1 read return
//   p2_en_x/p2_wr_x   port 2 request and write select (both active low)
//   p2_addr/p2_d      port 2 address and write data
//   p2_bit_wr_x       port 2 per-bit write enable (active low)
//   p2_busy           port 2 request not accepted this cycle
//   p2_rvalid/rdata   port 2 read return
//   mem_*             memory control/address/data (active-low controls)
//   mem_q             memory read data, valid one cycle after a read
//
// Revision : 1.0 - initial release
// ============================================================================
module imem_access_sched #(
  parameter int PORTW     = 32,
  parameter int ADDRWIDTH = 7,
  parameter int MAXWAIT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 p1_en_x,
  input  logic [ADDRWIDTH-1:0] p1_addr,
  output logic                 p1_busy,
  output logic                 p1_rvalid,
  output logic [PORTW-1:0]     p1_rdata,

  input  logic                 p2_en_x,
  input  logic                 p2_wr_x,
  input  logic [ADDRWIDTH-1:0] p2_addr,
  input  logic [PORTW-1:0]     p2_d,
  input  logic [PORTW-1:0]     p2_bit_wr_x,
  output logic                 p2_busy,
  output logic                 p2_rvalid,
  output logic [PORTW-1:0]     p2_rdata,

  output logic                 mem_en_x,
  output logic                 mem_wr_x,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [PORTW-1:0]     mem_d,
  output logic [PORTW-1:0]     mem_bit_wr_x,
  input  logic [PORTW-1:0]     mem_q
);

  localparam int                CW        = $clog2(MAXWAIT + 1);
  localparam logic [CW-1:0]     C_MAXWAIT = CW'(MAXWAIT);

  // --------------------------------------------------------------------------
  // Requests and grant arbitration
  // --------------------------------------------------------------------------
  logic          w_req1;
  logic          w_req2;
  logic          w_grant1;
  logic          w_grant2;
  logic          w_starved;
  logic [CW-1:0] r_wait_cnt;
  logic          r_rd1;
  logic          r_rd2;

  assign w_req1    = ~p1_en_x;
  assign w_req2    = ~p2_en_x;
  assign w_starved = (r_wait_cnt == C_MAXWAIT);

  // Port 2 wins when port 1 is idle or once it has lost MAXWAIT conflicts.
  // Both grants are forced low during reset so no access reaches memory.
  assign w_grant2 = ~rst & w_req2 & (~w_req1 | w_starved);
  assign w_grant1 = ~rst & w_req1 & ~w_grant2;

  assign p1_busy = w_req1 & ~w_grant1;
  assign p2_busy = w_req2 & ~w_grant2;

  // --------------------------------------------------------------------------
  // Memory request mux (combinational, zero added latency)
  // --------------------------------------------------------------------------
  always_comb begin
    mem_en_x     = 1'b1;
    mem_wr_x     = 1'b1;
    mem_addr     = p1_addr;
    mem_bit_wr_x = '1;
    if (w_grant2) begin
      mem_en_x     = 1'b0;
      mem_wr_x     = p2_wr_x;
      mem_addr     = p2_addr;
      mem_bit_wr_x = p2_bit_wr_x;
    end else if (w_grant1) begin
      mem_en_x     = 1'b0;
    end
  end

  // Write data needs no steering: it is ignored by memory unless port 2 owns
  // a write cycle.
  assign mem_d = p2_d;

  // --------------------------------------------------------------------------
  // Starvation counter
  // --------------------------------------------------------------------------
  // Counts consecutive cycles port 2 loses to port 1. Any cycle in which
  // port 2 is not requesting restarts the fairness window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (~w_req2 | w_grant2) begin
      r_wait_cnt <= '0;
    end else if (w_req1 & w_grant1 & ~w_starved) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Read ownership tracking and return path
  // --------------------------------------------------------------------------
  // The grants are exclusive, so at most one owner flag is set. A read
  // accepted just before reset rises still returns its pulse, because the
  // flag was captured while rst was low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd1 <= 1'b0;
      r_rd2 <= 1'b0;
    end else begin
      r_rd1 <= w_grant1;
      r_rd2 <= w_grant2 & p2_wr_x;
    end
  end

  assign p1_rvalid = r_rd1;
  assign p2_rvalid = r_rd2;
  assign p1_rdata  = mem_q;
  assign p2_rdata  = mem_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_access_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_access_sched
// Purpose  : Directed self-checking bench for imem_access_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_access_sched;

  localparam int PORTW     = 32;
  localparam int ADDRWIDTH = 7;
  localparam int MAXWAIT   = 4;

  logic                 clk;
  logic                 rst;
  logic                 p1_en_x;
  logic [ADDRWIDTH-1:0] p1_addr;
  logic                 p1_busy;
  logic                 p1_rvalid;
  logic [PORTW-1:0]     p1_rdata;
  logic                 p2_en_x;
  logic                 p2_wr_x;
  logic [ADDRWIDTH-1:0] p2_addr;
  logic [PORTW-1:0]     p2_d;
  logic [PORTW-1:0]     p2_bit_wr_x;
  logic                 p2_busy;
  logic                 p2_rvalid;
  logic [PORTW-1:0]     p2_rdata;
  logic                 mem_en_x;
  logic                 mem_wr_x;
  logic [ADDRWIDTH-1:0] mem_addr;
  logic [PORTW-1:0]     mem_d;
  logic [PORTW-1:0]     mem_bit_wr_x;
  logic [PORTW-1:0]     mem_q;

  int n_checks;
  int n_fail;

  imem_access_sched #(
    .PORTW    (PORTW),
    .ADDRWIDTH(ADDRWIDTH),
    .MAXWAIT  (MAXWAIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .p1_en_x     (p1_en_x),
    .p1_addr     (p1_addr),
    .p1_busy     (p1_busy),
    .p1_rvalid   (p1_rvalid),
    .p1_rdata    (p1_rdata),
    .p2_en_x     (p2_en_x),
    .p2_wr_x     (p2_wr_x),
    .p2_addr     (p2_addr),
    .p2_d        (p2_d),
    .p2_bit_wr_x (p2_bit_wr_x),
    .p2_busy     (p2_busy),
    .p2_rvalid   (p2_rvalid),
    .p2_rdata    (p2_rdata),
    .mem_en_x    (mem_en_x),
    .mem_wr_x    (mem_wr_x),
    .mem_addr    (mem_addr),
    .mem_d       (mem_d),
    .mem_bit_wr_x(mem_bit_wr_x),
    .mem_q       (mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge: registered outputs reflect
  // the previous cycle; new inputs are applied from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after input changes.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    p1_en_x     = 1'b1;
    p1_addr     = '0;
    p2_en_x     = 1'b1;
    p2_wr_x     = 1'b1;
    p2_addr     = '0;
    p2_d        = '0;
    p2_bit_wr_x = '1;
    mem_q       = '0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst     = 1'b1;
    idle_inputs();
    p1_en_x = 1'b0;
    p2_en_x = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      n_checks++;
      if (mem_en_x !== 1'b1) begin
        n_fail++; $display("FAIL reset_mem_en_x cyc%0d got %b exp 1", i, mem_en_x);
      end
      n_checks++;
      if (p1_busy !== 1'b1 || p2_busy !== 1'b1) begin
        n_fail++; $display("FAIL reset_busy cyc%0d got p1=%b p2=%b exp 1 1", i, p1_busy, p2_busy);
      end
      n_checks++;
      if (p1_rvalid !== 1'b0 || p2_rvalid !== 1'b0) begin
        n_fail++; $display("FAIL reset_rvalid cyc%0d got p1=%b p2=%b exp 0 0", i, p1_rvalid, p2_rvalid);
      end
    end
    tick();
    rst = 1'b0;
    idle_inputs();
    settle();
    n_checks++;
    if (mem_en_x !== 1'b1 || mem_wr_x !== 1'b1 || mem_bit_wr_x !== '1) begin
      n_fail++; $display("FAIL idle_mem got en=%b wr=%b mask=%h exp 1 1 ffffffff", mem_en_x, mem_wr_x, mem_bit_wr_x);
    end
    n_checks++;
    if (p1_busy !== 1'b0 || p2_busy !== 1'b0 || p1_rvalid !== 1'b0 || p2_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL idle_outputs got busy=%b%b rvalid=%b%b exp 00 00", p1_busy, p2_busy, p1_rvalid, p2_rvalid);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_p1_read();
    tick();
    idle_inputs();
    p1_en_x = 1'b0;
    p1_addr = 7'h05;
    settle();
    n_checks++;
    if (mem_addr !== 7'h05 || mem_en_x !== 1'b0 || mem_wr_x !== 1'b1 || p1_busy !== 1'b0) begin
      n_fail++; $display("FAIL p1_req got addr=%h en=%b wr=%b busy=%b exp 05 0 1 0", mem_addr, mem_en_x, mem_wr_x, p1_busy);
    end
    tick();
    idle_inputs();
    mem_q = 32'hDEADBEEF;
    settle();
    n_checks++;
    if (p1_rvalid !== 1'b1 || p1_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL p1_return got v=%b d=%h exp 1 deadbeef", p1_rvalid, p1_rdata);
    end
    n_checks++;
    if (p2_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL p1_return_p2v got %b exp 0", p2_rvalid);
    end
    tick();
    settle();
    n_checks++;
    if (p1_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL p1_rvalid_once got %b exp 0", p1_rvalid);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [PORTW-1:0] data [3];
    data[0] = 32'h11111111;
    data[1] = 32'h22222222;
    data[2] = 32'h33333333;
    for (int i = 0; i < 4; i++) begin
      tick();
      idle_inputs();
      if (i > 0) mem_q = data[i-1];
      if (i < 3) begin
        p1_en_x = 1'b0;
        p1_addr = 7'(i + 8);
      end
      settle();
      if (i < 3) begin
        n_checks++;
        if (mem_en_x !== 1'b0 || mem_addr !== 7'(i + 8) || p1_busy !== 1'b0) begin
          n_fail++; $display("FAIL b2b_req cyc%0d got en=%b addr=%h busy=%b exp 0 %h 0", i, mem_en_x, mem_addr, p1_busy, 7'(i + 8));
        end
      end
      if (i > 0) begin
        n_checks++;
        if (p1_rvalid !== 1'b1 || p1_rdata !== data[i-1]) begin
          n_fail++; $display("FAIL b2b_ret cyc%0d got v=%b d=%h exp 1 %h", i, p1_rvalid, p1_rdata, data[i-1]);
        end
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_conflict();
    logic prev_g1;
    logic prev_g2;
    logic exp_g2;
    tick();
    idle_inputs();
    settle();
    prev_g1 = 1'b0;
    prev_g2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      idle_inputs();
      p1_en_x = 1'b0;
      p1_addr = 7'h10;
      p2_en_x = 1'b0;
      p2_wr_x = 1'b1;
      p2_addr = 7'h20;
      settle();
      exp_g2 = (i == 4) || (i == 9);
      n_checks++;
      if (p2_busy !== !exp_g2 || p1_busy !== exp_g2) begin
        n_fail++; $display("FAIL conflict_busy cyc%0d got p1=%b p2=%b exp %b %b", i + 1, p1_busy, p2_busy, exp_g2, !exp_g2);
      end
      n_checks++;
      if (mem_addr !== (exp_g2 ? 7'h20 : 7'h10) || mem_en_x !== 1'b0) begin
        n_fail++; $display("FAIL conflict_mem cyc%0d got addr=%h en=%b exp %h 0", i + 1, mem_addr, mem_en_x, exp_g2 ? 7'h20 : 7'h10);
      end
      n_checks++;
      if (p1_rvalid !== prev_g1 || p2_rvalid !== prev_g2) begin
        n_fail++; $display("FAIL conflict_rvalid cyc%0d got p1=%b p2=%b exp %b %b", i + 1, p1_rvalid, p2_rvalid, prev_g1, prev_g2);
      end
      prev_g1 = !exp_g2;
      prev_g2 = exp_g2;
    end
    tick();
    idle_inputs();
    settle();
    n_checks++;
    if (p2_rvalid !== 1'b1 || p1_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL conflict_last_rvalid got p1=%b p2=%b exp 0 1", p1_rvalid, p2_rvalid);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_p2_write_conflict();
    tick();
    idle_inputs();
    settle();
    for (int i = 0; i < 5; i++) begin
      tick();
      idle_inputs();
      p1_en_x     = 1'b0;
      p1_addr     = 7'h01;
      p2_en_x     = 1'b0;
      p2_wr_x     = 1'b0;
      p2_addr     = 7'h7F;
      p2_d        = 32'h12345678;
      p2_bit_wr_x = '0;
      settle();
      if (i < 4) begin
        n_checks++;
        if (p2_busy !== 1'b1 || mem_wr_x !== 1'b1) begin
          n_fail++; $display("FAIL wr_wait cyc%0d got p2_busy=%b wr=%b exp 1 1", i, p2_busy, mem_wr_x);
        end
      end
    end
    n_checks++;
    if (mem_wr_x !== 1'b0 || mem_en_x !== 1'b0 || mem_d !== 32'h12345678 || mem_addr !== 7'h7F || mem_bit_wr_x !== '0) begin
      n_fail++; $display("FAIL wr_mem got en=%b wr=%b addr=%h d=%h mask=%h exp 0 0 7f 12345678 0", mem_en_x, mem_wr_x, mem_addr, mem_d, mem_bit_wr_x);
    end
    n_checks++;
    if (p1_busy !== 1'b1 || p2_busy !== 1'b0) begin
      n_fail++; $display("FAIL wr_busy got p1=%b p2=%b exp 1 0", p1_busy, p2_busy);
    end
    tick();
    idle_inputs();
    settle();
    n_checks++;
    if (p1_rvalid !== 1'b0 || p2_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL wr_no_rvalid got p1=%b p2=%b exp 0 0", p1_rvalid, p2_rvalid);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_p2_drop();
    logic exp_busy;
    tick();
    idle_inputs();
    settle();
    // 3 conflict cycles, 1 cycle port 2 idle, then conflict again: port 2
    // must lose a fresh 4 cycles before being granted on the 5th.
    for (int i = 0; i < 9; i++) begin
      tick();
      idle_inputs();
      p1_en_x = 1'b0;
      p1_addr = 7'h02;
      p2_en_x = (i == 3) ? 1'b1 : 1'b0;
      p2_addr = 7'h40;
      settle();
      if (i != 3) begin
        exp_busy = (i != 8);
        n_checks++;
        if (p2_busy !== exp_busy) begin
          n_fail++; $display("FAIL drop_p2_busy cyc%0d got %b exp %b", i, p2_busy, exp_busy);
        end
      end else begin
        n_checks++;
        if (p1_busy !== 1'b0 || p2_busy !== 1'b0 || mem_addr !== 7'h02) begin
          n_fail++; $display("FAIL drop_gap got p1=%b p2=%b addr=%h exp 0 0 02", p1_busy, p2_busy, mem_addr);
        end
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_after_read();
    tick();
    idle_inputs();
    settle();
    tick();
    idle_inputs();
    p2_en_x = 1'b0;
    p2_wr_x = 1'b1;
    p2_addr = 7'h33;
    settle();
    n_checks++;
    if (p2_busy !== 1'b0 || mem_en_x !== 1'b0 || mem_addr !== 7'h33) begin
      n_fail++; $display("FAIL rar_req got busy=%b en=%b addr=%h exp 0 0 33", p2_busy, mem_en_x, mem_addr);
    end
    tick();
    rst     = 1'b1;
    mem_q   = 32'hCAFEF00D;
    p1_en_x = 1'b0;
    settle();
    n_checks++;
    if (p2_rvalid !== 1'b1 || p2_rdata !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL rar_rvalid got v=%b d=%h exp 1 cafef00d", p2_rvalid, p2_rdata);
    end
    n_checks++;
    if (mem_en_x !== 1'b1 || p1_busy !== 1'b1 || p2_busy !== 1'b1) begin
      n_fail++; $display("FAIL rar_mem got en=%b busy=%b%b exp 1 11", mem_en_x, p1_busy, p2_busy);
    end
    tick();
    settle();
    n_checks++;
    if (p2_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL rar_clear got p1=%b p2=%b exp 0 0", p1_rvalid, p2_rvalid);
    end
    tick();
    rst = 1'b0;
    idle_inputs();
    settle();
  endtask

  // --------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_p1_read();
    test_back_to_back();
    test_conflict();
    test_p2_write_conflict();
    test_p2_drop();
    test_reset_after_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
